// File: rtl/spi_pkg.sv
// Shared definitions for the mode-0 SPI master: FSM state encoding, SPI mode
// constants and the transfer latency helper.
package spi_pkg;

    // Master FSM states
    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        GAP,
        HOLD,
        CSIDLE
    } spi_state_t;

    // SPI mode 0: SCLK idles low, data sampled on the rising edge
    localparam logic SPI_CPOL = 1'b0;
    localparam logic SPI_CPHA = 1'b0;

    // Clock edges from the accept edge to the edge on which o_rx_valid rises
    function automatic int spi_latency(input int clk_div, input int data_width,
                                       input int cs_setup_cyc);
        return cs_setup_cyc + 2 * clk_div * data_width;
    endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// SCLK divider: while enabled, toggles o_sclk every CLK_DIV cycles, starting
// with a full low half-period. o_rise/o_fall flag the cycle at whose closing
// edge o_sclk goes 0->1 / 1->0. Disabling parks SCLK at the idle level.
module spi_clk_gen
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 8
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_en,
    output logic o_sclk,
    output logic o_rise,
    output logic o_fall
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt;
    logic             half_done;

    assign half_done = i_en && (div_cnt == DIV_MAX);
    assign o_rise    = half_done && (o_sclk == SPI_CPOL);
    assign o_fall    = half_done && (o_sclk != SPI_CPOL);

    // Half-period counter and SCLK toggle; restarts from zero on every enable
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            div_cnt <= '0;
            o_sclk  <= SPI_CPOL;
        end else if (!i_en) begin
            div_cnt <= '0;
            o_sclk  <= SPI_CPOL;
        end else if (half_done) begin
            div_cnt <= '0;
            o_sclk  <= ~o_sclk;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/spi_master.sv
// Mode-0 (CPOL=0, CPHA=0), MSB-first SPI master with a valid/ready byte
// stream. CS_n stays low across a burst until a word flagged last completes.
//
// Latency: o_rx_valid rises CS_SETUP_CYC + 2*CLK_DIV*DATA_WIDTH clock edges
// after the edge that accepts a word from IDLE (spi_pkg::spi_latency).
//
// Optional build macro SPI_MASTER_LOOPBACK_EN: the receive path samples the
// master's own MOSI instead of i_miso (i_miso is then ignored).
module spi_master
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int CLK_DIV      = 8,
    parameter int CS_SETUP_CYC = 4,
    parameter int CS_HOLD_CYC  = 4,
    parameter int CS_IDLE_CYC  = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    output logic                  o_sclk,
    output logic                  o_cs_n,
    output logic                  o_mosi,
    input  logic                  i_miso,
    input  logic [DATA_WIDTH-1:0] i_tx_data,
    input  logic                  i_tx_last,
    input  logic                  i_tx_valid,
    output logic                  o_tx_ready,
    output logic [DATA_WIDTH-1:0] o_rx_data,
    output logic                  o_rx_valid,
    output logic                  o_busy
);

    localparam int BIT_W   = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BIT_W-1:0] BIT_MAX = BIT_W'(DATA_WIDTH - 1);
    localparam int MAX_CYC = (CS_SETUP_CYC > CS_HOLD_CYC)
                           ? ((CS_SETUP_CYC > CS_IDLE_CYC) ? CS_SETUP_CYC : CS_IDLE_CYC)
                           : ((CS_HOLD_CYC > CS_IDLE_CYC) ? CS_HOLD_CYC : CS_IDLE_CYC);
    localparam int CYC_W   = $clog2(MAX_CYC + 1);

    spi_state_t            state;
    spi_state_t            next_state;
    logic [DATA_WIDTH-1:0] tx_shift;
    logic [DATA_WIDTH-1:0] rx_shift;
    logic                  last_flag;
    logic [BIT_W-1:0]      bit_cnt;
    logic [CYC_W-1:0]      cyc_cnt;
    logic                  cyc_done;
    logic                  accept;
    logic                  word_done;
    logic                  sclk_en;
    logic                  sclk_rise;
    logic                  sclk_fall;
    logic                  mosi_int;
    logic                  rx_bit;

    spi_clk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_gen (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_en    (sclk_en),
        .o_sclk  (o_sclk),
        .o_rise  (sclk_rise),
        .o_fall  (sclk_fall)
    );

    assign accept    = i_tx_valid && o_tx_ready;
    assign word_done = sclk_fall && (bit_cnt == '0);
    assign o_mosi    = mosi_int;

`ifdef SPI_MASTER_LOOPBACK_EN
    assign rx_bit = mosi_int;
`else
    logic [1:0] miso_sync;

    // Two-flop synchronizer for the asynchronous MISO input
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            miso_sync <= '0;
        end else begin
            miso_sync <= {miso_sync[0], i_miso};
        end
    end

    assign rx_bit = miso_sync[1];
`endif

    // Terminal count for the CS setup, hold and idle timers
    always_comb begin
        cyc_done = 1'b0;
        case (state)
            SETUP:   cyc_done = (cyc_cnt == CYC_W'(CS_SETUP_CYC - 1));
            HOLD:    cyc_done = (cyc_cnt == CYC_W'(CS_HOLD_CYC - 1));
            CSIDLE:  cyc_done = (cyc_cnt == CYC_W'(CS_IDLE_CYC - 1));
            default: cyc_done = 1'b0;
        endcase
    end

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept)    next_state = SETUP;
            SETUP:   if (cyc_done)  next_state = SHIFT;
            SHIFT:   if (word_done) next_state = last_flag ? HOLD : GAP;
            GAP:     if (accept)    next_state = SHIFT;
            HOLD:    if (cyc_done)  next_state = CSIDLE;
            CSIDLE:  if (cyc_done)  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // State-decoded outputs: CS is low from SETUP through HOLD
    always_comb begin
        o_tx_ready = 1'b0;
        o_cs_n     = 1'b1;
        o_busy     = 1'b1;
        sclk_en    = 1'b0;
        mosi_int   = 1'b0;
        case (state)
            IDLE: begin
                o_tx_ready = 1'b1;
                o_busy     = 1'b0;
            end
            SETUP, HOLD: begin
                o_cs_n   = 1'b0;
                mosi_int = tx_shift[DATA_WIDTH-1];
            end
            SHIFT: begin
                o_cs_n   = 1'b0;
                sclk_en  = 1'b1;
                mosi_int = tx_shift[DATA_WIDTH-1];
            end
            GAP: begin
                o_tx_ready = 1'b1;
                o_cs_n     = 1'b0;
                mosi_int   = tx_shift[DATA_WIDTH-1];
            end
            default: begin
                o_cs_n = 1'b1;
            end
        endcase
    end

    // CS timer: counts only inside SETUP/HOLD/CSIDLE, cleared at terminal count
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cyc_cnt <= '0;
        end else if (cyc_done || !(state == SETUP || state == HOLD || state == CSIDLE)) begin
            cyc_cnt <= '0;
        end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
        end
    end

    // Shift registers, bit counter and the received-word pulse
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            tx_shift   <= '0;
            rx_shift   <= '0;
            last_flag  <= 1'b0;
            bit_cnt    <= '0;
            o_rx_data  <= '0;
            o_rx_valid <= 1'b0;
        end else begin
            o_rx_valid <= 1'b0;
            if (accept) begin
                tx_shift  <= i_tx_data;
                last_flag <= i_tx_last;
                bit_cnt   <= BIT_MAX;
            end else if (sclk_fall) begin
                tx_shift <= {tx_shift[DATA_WIDTH-2:0], 1'b0};
                bit_cnt  <= (bit_cnt == '0) ? BIT_MAX : bit_cnt - 1'b1;
            end
            if (sclk_rise) begin
                rx_shift <= {rx_shift[DATA_WIDTH-2:0], rx_bit};
            end
            if (word_done) begin
                o_rx_data  <= rx_shift;
                o_rx_valid <= 1'b1;
            end
        end
    end

endmodule
